// File: rtl/tdm_demux_1x8.sv
// Receive-side 1-to-8 TDM demultiplexer with hunt/lock framing.
// One bit per valid beat lands in a per-slot cell; the frame is published on Y at slot 7.

module tdm_slot_cell #(
  parameter bit LAST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic load,
  input  logic d,
  output logic y
);
  logic shadow;
  logic src;

  // The final slot publishes straight from the line; its shadow bit never feeds Y.
  assign src = LAST ? d : shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= 1'b0;
      y      <= 1'b0;
    end else begin
      if (wr)   shadow <= d;
      if (load) y      <= src;
    end
  end
endmodule

module tdm_demux_1x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       fsync,
  output logic [7:0] Y,
  output logic       frame_valid,
  output logic [2:0] sel,
  output logic       locked,
  output logic       sync_err
);
  localparam int NUM_SLOTS = 8;

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  typedef struct packed {
    logic vld;
    logic sync;
    logic bit_d;
  } beat_t;

  state_t                 state, state_nxt;
  beat_t                  beat;
  logic [2:0]             sel_nxt;
  logic [NUM_SLOTS-1:0]   wr;
  logic                   load;
  logic                   fv_nxt;
  logic                   err_nxt;

  assign beat = '{vld: din_valid, sync: fsync, bit_d: din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      sel         <= 3'd0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      frame_valid <= fv_nxt;
      sync_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    wr        = '0;
    load      = 1'b0;
    fv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (beat.vld) begin
      unique case (state)
        HUNT: begin
          // Non-sync beats are dropped silently while hunting.
          if (beat.sync) begin
            wr[0]     = 1'b1;
            sel_nxt   = 3'd1;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (beat.sync) begin
            // A sync anywhere but slot 0 restarts the frame and is flagged.
            err_nxt = (sel != 3'd0);
            wr[0]   = 1'b1;
            sel_nxt = 3'd1;
          end else if (sel == 3'd0) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end else if (sel == 3'd7) begin
            load    = 1'b1;
            fv_nxt  = 1'b1;
            sel_nxt = 3'd0;
          end else begin
            wr[sel] = 1'b1;
            sel_nxt = sel + 3'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCK);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    tdm_slot_cell #(.LAST(i == NUM_SLOTS - 1)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[i]),
      .load  (load),
      .d     (beat.bit_d),
      .y     (Y[i])
    );
  end
endmodule
